// File: rtl/scramble.sv
// -----------------------------------------------------------------------------
// scramble
//
// Transmit-side 802.11 OFDM data scrambler. The serial DATA-field bit stream
// (SERVICE, PSDU and pad bits) is whitened with the 7-bit LFSR x^7 + x^4 + 1.
// The LFSR is loaded from a seed at the start of each frame. Tail bits are
// forced to zero after scrambling, which the convolutional encoder needs to
// return to the all-zero state. Sits between the PSDU bit serializer and the
// convolutional encoder.
//
// Parameters:
//   COUNT_WIDTH   width of the per-frame scrambled-bit counter
//   DEFAULT_SEED  seed used instead of a zero seed (zero would lock the LFSR)
//
// Ports:
//   clock          in   system clock, rising edge
//   reset_n        in   synchronous active-low reset
//   enable         in   global enable; low freezes all state
//   start          in   one-cycle frame start, loads the seed
//   seed[6:0]      in   scrambler initial state, sampled with start
//   in_bit         in   data bit
//   input_strobe   in   in_bit valid this cycle
//   tail_flag      in   strobed bit is a tail bit (output forced to 0)
//   last           in   strobed bit is the final bit of the frame
//   out_bit        out  scrambled bit, holds when output_strobe is low
//   output_strobe  out  one-cycle pulse per accepted bit
//   busy           out  high while a frame is being scrambled
//   bit_count      out  bits scrambled in the current frame, saturating
// -----------------------------------------------------------------------------
module scramble #(
    parameter int         COUNT_WIDTH  = 16,
    parameter logic [6:0] DEFAULT_SEED = 7'h5D
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   start,
    input  logic [6:0]             seed,
    input  logic                   in_bit,
    input  logic                   input_strobe,
    input  logic                   tail_flag,
    input  logic                   last,
    output logic                   out_bit,
    output logic                   output_strobe,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] bit_count
);

    typedef enum logic {
        IDLE     = 1'b0,
        SCRAMBLE = 1'b1
    } fsm_t;

    fsm_t                   fsm_q, fsm_d;
    logic [6:0]             lfsr_q, lfsr_d;
    logic                   out_bit_q, out_bit_d;
    logic                   strobe_q, strobe_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic                   load_seed;
    logic                   accept;
    logic                   fb;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic. start has priority over a coincident last bit.
    // -------------------------------------------------------------------------
    always_comb begin
        fsm_d = fsm_q;
        if (load_seed) begin
            fsm_d = SCRAMBLE;
        end else if (accept && last) begin
            fsm_d = IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // FSM outputs / decoded controls. A strobe coinciding with start is
    // discarded, and strobes outside a frame are ignored.
    // -------------------------------------------------------------------------
    always_comb begin
        load_seed = enable & start;
        accept    = enable & input_strobe & ~start & (fsm_q == SCRAMBLE);
        busy      = (fsm_q == SCRAMBLE);
    end

    // -------------------------------------------------------------------------
    // Datapath next-state: LFSR, registered output bit/strobe, bit counter
    // -------------------------------------------------------------------------
    always_comb begin
        fb        = lfsr_q[6] ^ lfsr_q[3];
        lfsr_d    = lfsr_q;
        out_bit_d = out_bit_q;
        strobe_d  = 1'b0;
        count_d   = count_q;

        if (load_seed) begin
            lfsr_d  = (seed == 7'd0) ? DEFAULT_SEED : seed;
            count_d = '0;
        end else if (accept) begin
            // Tail bits still step the LFSR so the sequence stays aligned.
            lfsr_d    = {lfsr_q[5:0], fb};
            out_bit_d = tail_flag ? 1'b0 : (in_bit ^ fb);
            strobe_d  = 1'b1;
            if (!(&count_q)) begin
                count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lfsr_q    <= 7'd0;
            out_bit_q <= 1'b0;
            strobe_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            lfsr_q    <= lfsr_d;
            out_bit_q <= out_bit_d;
            strobe_q  <= strobe_d;
            count_q   <= count_d;
        end
    end

    assign out_bit       = out_bit_q;
    assign output_strobe = strobe_q;
    assign bit_count     = count_q;

endmodule

// File: doc/scramble.md
# scramble

Transmit-side 802.11 OFDM data scrambler, the transmit counterpart of the receive descrambler. It whitens the serial DATA-field bit stream (SERVICE, PSDU and pad bits) with the 7-bit LFSR x^7 + x^4 + 1, loaded per frame from a seed. It forces the six tail bits to zero after scrambling, as the convolutional encoder requires. It sits between the PSDU bit serializer and the convolutional encoder in the TX chain.

## Interface
Parameters:
- `COUNT_WIDTH`, default 16: width of the per-frame scrambled-bit counter.
- `DEFAULT_SEED`, default 7'h5D: seed substituted when `seed` is zero at frame start.

Ports:
- `clock`  input  1  system clock; all logic on the rising edge.
- `reset_n`  input  1  reset, synchronous and active-low.
- `enable`  input  1  global enable. While low: state frozen, inputs ignored, `output_strobe` = 0.
- `start`  input  1  one-cycle pulse that begins a frame and loads the seed.
- `seed`  input  7  scrambler initial state, sampled only when `start` = 1.
- `in_bit`  input  1  data bit.
- `input_strobe`  input  1  `in_bit` is valid this cycle.
- `tail_flag`  input  1  qualifies a strobed bit as a tail bit; the output is forced to 0.
- `last`  input  1  qualifies a strobed bit as the final bit of the frame.
- `out_bit`  output  1  scrambled bit.
- `output_strobe`  output  1  `out_bit` is valid; one-cycle pulse per accepted bit.
- `busy`  output  1  high while the FSM is in SCRAMBLE.
- `bit_count`  output  COUNT_WIDTH  bits scrambled in the current frame; saturates at all-ones.

## Operation
- Reset (`reset_n` = 0 at a clock edge), all outputs and state cleared:
  - `out_bit` = 0, `output_strobe` = 0, `busy` = 0, `bit_count` = 0.
  - LFSR state = 0; FSM = IDLE.
- LFSR: `state[6:0]`, `fb = state[6] ^ state[3]`.
  - On each accepted bit: `state <= {state[5:0], fb}`.
  - Output `in_bit ^ fb`, or 0 when `tail_flag` = 1.
  - Tail bits still advance the LFSR.
- FSM states: IDLE, SCRAMBLE.
  - IDLE: `input_strobe` ignored and no output generated. `start` loads the seed, clears `bit_count` and moves to SCRAMBLE.
  - SCRAMBLE: each `enable & input_strobe` cycle accepts one bit, produces one output, and increments `bit_count` (saturating).
  - An accepted bit with `last` = 1 is output normally; the FSM then returns to IDLE. `bit_count` holds its final value until the next `start`.
  - `start` in SCRAMBLE aborts the frame: reload seed, clear `bit_count`, remain in SCRAMBLE.
- Seed handling: `state <= (seed == 0) ? DEFAULT_SEED : seed`. A zero seed would lock up the LFSR, so it is never loaded.
- Simultaneous `start` and `input_strobe`: `start` wins.
  - The strobed bit is discarded and no output is produced that cycle.
  - Upstream must not strobe data in the start cycle.
- `start` with `enable` = 0 is ignored.
- `tail_flag` and `last` are don't-care when `input_strobe` = 0.

## Timing
- Latency: 1 cycle. A bit accepted at edge N appears on `out_bit` with `output_strobe` = 1 after edge N, i.e. valid during cycle N+1.
- `out_bit` holds its last value when `output_strobe` = 0.
- Throughput: one bit per clock; back-to-back strobes are supported with no bubbles.
- `busy` rises the cycle after `start`. It falls the cycle after the accepted `last` bit, coincident with that bit's `output_strobe`.
- `bit_count` updates in the same cycle as the corresponding `output_strobe`.
- Reset mid-frame: outputs are cleared at the next edge and any in-flight `output_strobe` is suppressed.
- `enable` dropping mid-frame: the LFSR and counter hold; the frame resumes when `enable` returns.

## Test plan
- Reference sequence:
  - Stimulus: `start` with seed 7'h7F, then 16 zero bits strobed back-to-back.
  - Required: `out_bit` sequence 0000111011110010 and `bit_count` = 16.
- Zero seed and round trip:
  - Stimulus: `start` with seed 0, then 127 zero bits.
  - Required: output equals the DEFAULT_SEED sequence and is never all-zero.
  - Also feed the output through the descrambler; the 127 recovered bits must equal the input.
- Tail zeroing:
  - Stimulus: 24 random bits, then 6 bits of all-ones with `tail_flag` = 1, then 8 more bits.
  - Required: the 6 tail outputs are 0. The following 8 outputs match a golden model whose LFSR advanced through the tail.
- Framing:
  - Stimulus: `last` on bit 10, then 5 strobes in IDLE.
  - Required: exactly 10 output strobes, `busy` low after bit 10, `bit_count` holds at 10.
- Abort and collision:
  - Stimulus: `start` mid-frame coincident with `input_strobe`.
  - Required: no output that cycle, sequence restarts from the new seed, `bit_count` = 0.
- Enable and reset:
  - Stimulus: `enable` low for 3 cycles mid-frame, then resume; separately assert `reset_n` = 0 mid-frame.
  - Required: stalls cause no sequence skip. After reset all outputs are 0 and `busy` = 0.
